clock_time_ctrl: RTL and testbench

- Timekeeping controller for the board clock; consumes the one-cycle 1 Hz and 120 Hz tick pulses from the tick generator.
- Sequences HH:MM:SS BCD counting and a two-button set-mode FSM (mode/increment) with tick-based debouncing.
- Drives BCD digits plus per-field blank strobes to the seven-segment display mux.

---
 rtl/clock_time_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Board clock timekeeping controller.
// Counts HH:MM:SS in BCD from the 1 Hz tick. Two debounced buttons drive a set-mode FSM
// (mode cycles RUN -> SET_HR -> SET_MIN, inc bumps the field being set). The field being
// set blinks, timed from the fast tick.
module clock_time_ctrl #(
    parameter int unsigned H24            = 1,
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned BLINK_TICKS    = 60
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_1hz,
    input  logic       i_tick_fast,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    output logic [7:0] o_hours,
    output logic [7:0] o_mins,
    output logic [7:0] o_secs,
    output logic       o_pm,
    output logic [1:0] o_state,
    output logic       o_blank_hr,
    output logic       o_blank_min
);

    localparam int unsigned DbW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int unsigned BlW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [DbW-1:0] DbLast  = DbW'(DEBOUNCE_TICKS - 1);
    localparam logic [BlW-1:0] BlLast  = BlW'(BLINK_TICKS - 1);
    localparam logic [7:0]     HrReset = (H24 != 0) ? 8'h00 : 8'h12;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Index 0 = mode button, index 1 = inc button
    logic [1:0]     btn_raw;
    logic [1:0]     db_stable_q;
    logic [1:0]     db_prev_q;
    logic [1:0]     press_q;
    logic [DbW-1:0] db_cnt_q [2];

    logic mode_press;
    logic inc_press;

    logic [7:0] hours_q, hours_d;
    logic [7:0] mins_q, mins_d;
    logic [7:0] secs_q, secs_d;
    logic       pm_q, pm_d;
    logic [7:0] hr_inc;
    logic       pm_inc;

    logic [BlW-1:0] blink_cnt_q;
    logic           phase_q;

    // Units digit rolls 9 -> 0 with carry into tens; callers handle field wrap
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] min_sec_inc(input logic [7:0] v);
        return (v == 8'h59) ? 8'h00 : bcd_inc(v);
    endfunction

    assign btn_raw    = {i_btn_inc, i_btn_mode};
    assign mode_press = press_q[0];
    // Mode wins over a coincident inc
    assign inc_press  = press_q[1] & ~press_q[0];

    // Debounce both buttons on fast ticks; the press pulse is registered off the stable edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            db_stable_q <= '0;
            db_prev_q   <= '0;
            press_q     <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            db_prev_q <= db_stable_q;
            press_q   <= db_stable_q & ~db_prev_q;
            for (int b = 0; b < 2; b++) begin
                if (i_tick_fast) begin
                    if (btn_raw[b] == db_stable_q[b]) begin
                        db_cnt_q[b] <= '0;
                    end else if (db_cnt_q[b] == DbLast) begin
                        db_stable_q[b] <= ~db_stable_q[b];
                        db_cnt_q[b]    <= '0;
                    end else begin
                        db_cnt_q[b] <= db_cnt_q[b] + DbW'(1);
                    end
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: each mode press advances one step around the ring
    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                StRun:   state_d = StSetHr;
                StSetHr: state_d = StSetMin;
                default: state_d = StRun;
            endcase
        end
    end

    // FSM outputs: blanking only applies to the field being set
    always_comb begin
        o_state     = state_q;
        o_blank_hr  = (state_q == StSetHr) & phase_q;
        o_blank_min = (state_q == StSetMin) & phase_q;
        o_pm        = (H24 != 0) ? 1'b0 : pm_q;
    end

    // Next hour value and PM flag for a single hour step in either mode
    always_comb begin
        hr_inc = bcd_inc(hours_q);
        pm_inc = pm_q;
        if (H24 != 0) begin
            if (hours_q == 8'h23) hr_inc = 8'h00;
        end else begin
            if (hours_q == 8'h12) hr_inc = 8'h01;
            if (hours_q == 8'h11) pm_inc = ~pm_q;
        end
    end

    // Time next state: tick counting in RUN, field increments in SET, seconds clear on exit
    always_comb begin
        hours_d = hours_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        pm_d    = pm_q;
        if (state_q == StRun && i_tick_1hz) begin
            secs_d = min_sec_inc(secs_q);
            if (secs_q == 8'h59) begin
                mins_d = min_sec_inc(mins_q);
                if (mins_q == 8'h59) begin
                    hours_d = hr_inc;
                    pm_d    = pm_inc;
                end
            end
        end
        if (state_q == StSetHr && inc_press) begin
            hours_d = hr_inc;
            pm_d    = pm_inc;
        end
        if (state_q == StSetMin && inc_press) begin
            mins_d = min_sec_inc(mins_q);
        end
        if (state_q == StSetMin && mode_press) begin
            secs_d = 8'h00;
        end
    end

    // Time registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hours_q <= HrReset;
            mins_q  <= 8'h00;
            secs_q  <= 8'h00;
            pm_q    <= 1'b0;
        end else begin
            hours_q <= hours_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            pm_q    <= pm_d;
        end
    end

    // Blink timer: restarts visible on entering a SET state and on every inc press
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (state_q == StRun || mode_press || inc_press) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (i_tick_fast) begin
            if (blink_cnt_q == BlLast) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BlW'(1);
            end
        end
    end

    assign o_hours = hours_q;
    assign o_mins  = mins_q;
    assign o_secs  = secs_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: a 24 h and a 12 h instance share stimulus. Stimulus pushes
// expected snapshots into a queue; a negedge monitor pops and compares them.
module tb_clock_time_ctrl;

    logic clk;
    logic rst;
    logic tick_1hz;
    logic tick_fast;
    logic btn_mode;
    logic btn_inc;

    logic [7:0] hr0, mn0, sc0, hr1, mn1, sc1;
    logic       pm0, pm1, bh0, bm0, bh1, bm1;
    logic [1:0] st0, st1;

    typedef struct packed {
        logic       dut;
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sc;
        logic       pm;
        logic [1:0] st;
        logic       bh;
        logic       bm;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    clock_time_ctrl #(.H24(1), .DEBOUNCE_TICKS(3), .BLINK_TICKS(60)) u_dut24 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_tick_1hz  (tick_1hz),
        .i_tick_fast (tick_fast),
        .i_btn_mode  (btn_mode),
        .i_btn_inc   (btn_inc),
        .o_hours     (hr0),
        .o_mins      (mn0),
        .o_secs      (sc0),
        .o_pm        (pm0),
        .o_state     (st0),
        .o_blank_hr  (bh0),
        .o_blank_min (bm0)
    );

    clock_time_ctrl #(.H24(0), .DEBOUNCE_TICKS(3), .BLINK_TICKS(60)) u_dut12 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_tick_1hz  (tick_1hz),
        .i_tick_fast (tick_fast),
        .i_btn_mode  (btn_mode),
        .i_btn_inc   (btn_inc),
        .o_hours     (hr1),
        .o_mins      (mn1),
        .o_secs      (sc1),
        .o_pm        (pm1),
        .o_state     (st1),
        .o_blank_hr  (bh1),
        .o_blank_min (bm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the selected instance
    exp_t  mon_e;
    exp_t  mon_a;
    string mon_n;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            if (mon_e.dut) mon_a = {1'b1, hr1, mn1, sc1, pm1, st1, bh1, bm1};
            else           mon_a = {1'b0, hr0, mn0, sc0, pm0, st0, bh0, bm0};
            n_tests++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got %h:%h:%h pm=%0b st=%0d blank=%0b%0b, required %h:%h:%h pm=%0b st=%0d blank=%0b%0b",
                         mon_n, mon_e.dut, mon_a.hr, mon_a.mn, mon_a.sc, mon_a.pm, mon_a.st,
                         mon_a.bh, mon_a.bm, mon_e.hr, mon_e.mn, mon_e.sc, mon_e.pm, mon_e.st,
                         mon_e.bh, mon_e.bm);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push_exp(input string nm, input logic d, input logic [7:0] h,
                            input logic [7:0] m, input logic [7:0] s, input logic p,
                            input logic [1:0] st, input logic bh, input logic bm);
        exp_t e;
        e = '{dut: d, hr: h, mn: m, sc: s, pm: p, st: st, bh: bh, bm: bm};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fast(input int n);
        repeat (n) begin
            tick_fast = 1'b1; cyc();
            tick_fast = 1'b0; cyc();
        end
    endtask

    task automatic slow(input int n);
        repeat (n) begin
            tick_1hz = 1'b1; cyc();
            tick_1hz = 1'b0; cyc();
        end
    endtask

    // Press is applied on the edge after the idle cycle following the 3rd fast tick;
    // optional 1 Hz tick lands on that same edge. Release adds 3 fast ticks.
    task automatic press(input logic m, input logic i, input logic with_1hz);
        btn_mode = m;
        btn_inc  = i;
        fast(2);
        tick_fast = 1'b1; cyc();
        tick_fast = 1'b0; cyc();
        tick_1hz  = with_1hz; cyc();
        tick_1hz  = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        fast(3);
    endtask

    task automatic inc_n(input int n);
        repeat (n) press(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; tick_fast = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        push_exp("reset_24h", 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
        push_exp("reset_12h", 1, 8'h12, 8'h00, 8'h00, 0, 2'd0, 0, 0);

        // Run counting and reset overriding a tick
        slow(3661);
        push_exp("run_3661", 0, 8'h01, 8'h01, 8'h01, 0, 2'd0, 0, 0);
        slow(5);
        push_exp("run_3666", 0, 8'h01, 8'h01, 8'h06, 0, 2'd0, 0, 0);
        tick_1hz = 1'b1; rst = 1'b1; cyc();
        tick_1hz = 1'b0; rst = 1'b0;
        push_exp("reset_midrun", 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);

        // Bounces shorter than the debounce window
        btn_mode = 1'b1; fast(2); btn_mode = 1'b0; fast(1);
        btn_mode = 1'b1; fast(2); btn_mode = 1'b0; fast(1);
        cyc(); cyc(); cyc();
        push_exp("bounce_ignored", 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);

        // Exact press latency
        btn_mode = 1'b1; fast(2);
        tick_fast = 1'b1; cyc();
        tick_fast = 1'b0; cyc();
        push_exp("press_edge1", 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
        cyc();
        push_exp("press_edge2", 0, 8'h00, 8'h00, 8'h00, 0, 2'd1, 0, 0);
        btn_mode = 1'b0; fast(3);

        // Blink: 3 release ticks already counted
        fast(56);
        push_exp("blink_59", 0, 8'h00, 8'h00, 8'h00, 0, 2'd1, 0, 0);
        fast(1);
        push_exp("blink_60", 0, 8'h00, 8'h00, 8'h00, 0, 2'd1, 1, 0);
        fast(60);
        push_exp("blink_120", 0, 8'h00, 8'h00, 8'h00, 0, 2'd1, 0, 0);

        // SET_HR: seconds frozen, inc wraps, inc unblanks
        slow(3);
        push_exp("sethr_frozen", 0, 8'h00, 8'h00, 8'h00, 0, 2'd1, 0, 0);
        fast(60);
        push_exp("sethr_blanked", 0, 8'h00, 8'h00, 8'h00, 0, 2'd1, 1, 0);
        for (int k = 1; k <= 24; k++) begin
            press(1'b0, 1'b1, 1'b0);
            slow(1);
            push_exp("sethr_inc", 0, to_bcd(k % 24), 8'h00, 8'h00, 0, 2'd1, 0, 0);
        end

        // Mode and inc together: mode wins
        press(1'b1, 1'b1, 1'b0);
        push_exp("mode_inc_same", 0, 8'h00, 8'h00, 8'h00, 0, 2'd2, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        push_exp("back_to_run", 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
        slow(5);
        push_exp("run_5s", 0, 8'h00, 8'h00, 8'h05, 0, 2'd0, 0, 0);
        press(1'b1, 1'b0, 1'b1);
        push_exp("mode_with_tick", 0, 8'h00, 8'h00, 8'h06, 0, 2'd1, 0, 0);

        // Set 23:59, minutes wrap without carry, exit clears seconds, midnight rollover
        inc_n(23);
        push_exp("set_hr_23", 0, 8'h23, 8'h00, 8'h06, 0, 2'd1, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        push_exp("enter_setmin", 0, 8'h23, 8'h00, 8'h06, 0, 2'd2, 0, 0);
        inc_n(59);
        push_exp("set_min_59", 0, 8'h23, 8'h59, 8'h06, 0, 2'd2, 0, 0);
        inc_n(1);
        push_exp("min_wrap", 0, 8'h23, 8'h00, 8'h06, 0, 2'd2, 0, 0);
        inc_n(59);
        press(1'b1, 1'b0, 1'b0);
        push_exp("exit_clears_s", 0, 8'h23, 8'h59, 8'h00, 0, 2'd0, 0, 0);
        slow(59);
        push_exp("run_235959", 0, 8'h23, 8'h59, 8'h59, 0, 2'd0, 0, 0);
        slow(1);
        push_exp("midnight_24h", 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);

        // 12 h instance
        rst = 1'b1; cyc(); rst = 1'b0;
        push_exp("reset2_12h", 1, 8'h12, 8'h00, 8'h00, 0, 2'd0, 0, 0);
        push_exp("reset2_24h", 0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        inc_n(1);
        push_exp("h12_wrap_01", 1, 8'h01, 8'h00, 8'h00, 0, 2'd1, 0, 0);
        inc_n(10);
        push_exp("h12_set_11", 1, 8'h11, 8'h00, 8'h00, 0, 2'd1, 0, 0);
        inc_n(1);
        push_exp("h12_set_12pm", 1, 8'h12, 8'h00, 8'h00, 1, 2'd1, 0, 0);
        inc_n(11);
        push_exp("h12_set_11pm", 1, 8'h11, 8'h00, 8'h00, 1, 2'd1, 0, 0);
        inc_n(12);
        push_exp("h12_set_11am", 1, 8'h11, 8'h00, 8'h00, 0, 2'd1, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        inc_n(59);
        press(1'b1, 1'b0, 1'b0);
        push_exp("h12_exit", 1, 8'h11, 8'h59, 8'h00, 0, 2'd0, 0, 0);
        slow(59);
        push_exp("h12_115959", 1, 8'h11, 8'h59, 8'h59, 0, 2'd0, 0, 0);
        slow(1);
        push_exp("h12_noon_pm", 1, 8'h12, 8'h00, 8'h00, 1, 2'd0, 0, 0);
        slow(3599);
        push_exp("h12_125959", 1, 8'h12, 8'h59, 8'h59, 1, 2'd0, 0, 0);
        slow(1);
        push_exp("h12_to_01", 1, 8'h01, 8'h00, 8'h00, 1, 2'd0, 0, 0);

        // Reset in SET_MIN, mid-blink and mid-debounce
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        push_exp("h12_setmin", 1, 8'h01, 8'h00, 8'h00, 1, 2'd2, 0, 0);
        fast(57);
        push_exp("h12_blink_min", 1, 8'h01, 8'h00, 8'h00, 1, 2'd2, 0, 1);
        btn_mode = 1'b1; fast(2);
        rst = 1'b1; cyc(); rst = 1'b0;
        push_exp("h12_reset_set", 1, 8'h12, 8'h00, 8'h00, 0, 2'd0, 0, 0);
        fast(1);
        cyc(); cyc(); cyc();
        push_exp("db_cnt_cleared", 1, 8'h12, 8'h00, 8'h00, 0, 2'd0, 0, 0);
        btn_mode = 1'b0; fast(2);
        cyc(); cyc();

        n_tests++;
        if (hr1 !== 8'h12 || mn1 !== 8'h00 || sc1 !== 8'h00 || st1 !== 2'd0 || pm1 !== 1'b0) begin
            n_fail++;
            $display("FAIL final_12h: got %h:%h:%h pm=%0b st=%0d, required 12:00:00 pm=0 st=0",
                     hr1, mn1, sc1, pm1, st1);
        end
        n_tests++;
        if (hr0 !== 8'h00 || mn0 !== 8'h00 || sc0 !== 8'h00 || st0 !== 2'd0) begin
            n_fail++;
            $display("FAIL final_24h: got %h:%h:%h st=%0d, required 00:00:00 st=0",
                     hr0, mn0, sc0, st0);
        end
        n_tests++;
        if (bh0 !== 1'b0 || bm0 !== 1'b0 || bh1 !== 1'b0 || bm1 !== 1'b0) begin
            n_fail++;
            $display("FAIL final_blank: got %0b%0b %0b%0b, required all 0", bh0, bm0, bh1, bm1);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d expectations pending, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
